// File: rtl/bin_dec_seq_if.sv
// Handshake and select-line bundle for the sequential binary-to-one-hot decoder.
// The master drives the code/control side; the slave (decoder) returns the decode.
interface bin_dec_seq_if #(
  parameter int IN_W    = 4,
  parameter int DWELL_W = 8
);
  localparam int OUT_W = 2**IN_W;

  logic               en;
  logic               mode;
  logic               in_valid;
  logic               in_ready;
  logic [IN_W-1:0]    in;
  logic [DWELL_W-1:0] dwell;
  logic [OUT_W-1:0]   bcode;
  logic [IN_W-1:0]    code;
  logic               out_valid;
  logic               wrap;

  modport master (
    output en, mode, in_valid, in, dwell,
    input  in_ready, bcode, code, out_valid, wrap
  );

  modport slave (
    input  en, mode, in_valid, in, dwell,
    output in_ready, bcode, code, out_valid, wrap
  );
endinterface

// File: rtl/bin_dec_seq.sv
// Registered binary-to-one-hot decoder with a direct (valid/ready) mode and a
// self-stepping scan mode with programmable dwell time per code.
module bin_dec_seq #(
  parameter int IN_W    = 4,
  parameter int DWELL_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  bin_dec_seq_if.slave  bus
);
  localparam int OUT_W = 2**IN_W;

  localparam logic [0:0] ST_DIRECT = 1'b0;
  localparam logic [0:0] ST_SCAN   = 1'b1;

  function automatic logic [OUT_W-1:0] onehot(input logic [IN_W-1:0] c);
    logic [OUT_W-1:0] v;
    v    = {OUT_W{1'b0}};
    v[c] = 1'b1;
    return v;
  endfunction

  logic [0:0]         r_state;
  logic [IN_W-1:0]    r_code;
  logic [OUT_W-1:0]   r_bcode;
  logic               r_out_valid;
  logic               r_wrap;
  logic [DWELL_W-1:0] r_cnt;
  logic               r_en_q;

  logic [0:0]         w_state_nxt;
  logic [IN_W-1:0]    w_code_nxt;
  logic [OUT_W-1:0]   w_bcode_nxt;
  logic               w_out_valid_nxt;
  logic               w_wrap_nxt;
  logic [DWELL_W-1:0] w_cnt_nxt;
  logic [IN_W-1:0]    w_code_inc;
  logic [DWELL_W-1:0] w_cnt_inc;

  assign w_code_inc = r_code + IN_W'(1);
  assign w_cnt_inc  = r_cnt + DWELL_W'(1);

  assign bus.in_ready  = ~rst & ~bus.mode & bus.en;
  assign bus.bcode     = r_bcode;
  assign bus.code      = r_code;
  assign bus.out_valid = r_out_valid;
  assign bus.wrap      = r_wrap;

  // Next-state decode; mode=0 always behaves as DIRECT so a ready input is never dropped.
  always_comb begin
    w_state_nxt     = r_state;
    w_code_nxt      = r_code;
    w_bcode_nxt     = r_bcode;
    w_out_valid_nxt = r_out_valid;
    w_wrap_nxt      = 1'b0;
    w_cnt_nxt       = r_cnt;
    if (!bus.mode) begin
      w_state_nxt = ST_DIRECT;
      if (!bus.en) begin
        w_bcode_nxt     = {OUT_W{1'b0}};
        w_out_valid_nxt = 1'b0;
      end else if (bus.in_valid) begin
        w_code_nxt      = bus.in;
        w_bcode_nxt     = onehot(bus.in);
        w_out_valid_nxt = 1'b1;
      end else if (!r_en_q) begin
        w_bcode_nxt     = onehot(r_code);
        w_out_valid_nxt = 1'b1;
      end else begin
        w_out_valid_nxt = r_out_valid;
      end
    end else if (r_state == ST_DIRECT) begin
      // Every scan entry restarts at code 0 with a fresh dwell.
      w_state_nxt     = ST_SCAN;
      w_code_nxt      = {IN_W{1'b0}};
      w_cnt_nxt       = {DWELL_W{1'b0}};
      w_bcode_nxt     = bus.en ? onehot({IN_W{1'b0}}) : {OUT_W{1'b0}};
      w_out_valid_nxt = bus.en;
    end else begin
      w_state_nxt = ST_SCAN;
      if (!bus.en) begin
        w_bcode_nxt     = {OUT_W{1'b0}};
        w_out_valid_nxt = 1'b0;
      end else if (!r_en_q) begin
        w_bcode_nxt     = onehot(r_code);
        w_out_valid_nxt = 1'b1;
        w_cnt_nxt       = {DWELL_W{1'b0}};
      end else if (r_cnt >= bus.dwell) begin
        // >= lets a shortened dwell take effect on the very next edge.
        w_cnt_nxt       = {DWELL_W{1'b0}};
        w_code_nxt      = w_code_inc;
        w_bcode_nxt     = onehot(w_code_inc);
        w_out_valid_nxt = 1'b1;
        w_wrap_nxt      = (w_code_inc == {IN_W{1'b0}});
      end else begin
        w_cnt_nxt       = w_cnt_inc;
        w_bcode_nxt     = onehot(r_code);
        w_out_valid_nxt = 1'b1;
      end
    end
  end

  // State and output registers; r_en_q resets high so a fresh reset does not self-light.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_DIRECT;
      r_code      <= {IN_W{1'b0}};
      r_bcode     <= {OUT_W{1'b0}};
      r_out_valid <= 1'b0;
      r_wrap      <= 1'b0;
      r_cnt       <= {DWELL_W{1'b0}};
      r_en_q      <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_code      <= w_code_nxt;
      r_bcode     <= w_bcode_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_wrap      <= w_wrap_nxt;
      r_cnt       <= w_cnt_nxt;
      r_en_q      <= bus.en;
    end
  end

  bin_dec_seq_chk #(.IN_W(IN_W)) u_chk (
    .clk       (clk),
    .rst       (rst),
    .bcode     (r_bcode),
    .code      (r_code),
    .out_valid (r_out_valid),
    .wrap      (r_wrap)
  );
endmodule

// Output invariants: the one-hot always matches code when valid and is blank otherwise.
module bin_dec_seq_chk #(
  parameter int IN_W = 4
) (
  input logic                 clk,
  input logic                 rst,
  input logic [(2**IN_W)-1:0] bcode,
  input logic [IN_W-1:0]      code,
  input logic                 out_valid,
  input logic                 wrap
);
  localparam int OUT_W = 2**IN_W;

  a_valid_onehot: assert property (@(posedge clk) disable iff (rst)
    out_valid |-> (bcode == (OUT_W'(1) << code)));
  a_blank: assert property (@(posedge clk) disable iff (rst)
    !out_valid |-> (bcode == {OUT_W{1'b0}}));
  a_wrap_at_zero: assert property (@(posedge clk) disable iff (rst)
    wrap |-> (out_valid && code == {IN_W{1'b0}}));
endmodule

// File: doc/bin_dec_seq.md
Name: bin_dec_seq

Overview:
Parametrised, registered binary-to-one-hot decoder: IN_W-bit code in, 2**IN_W-bit one-hot out. It is the sequential successor of the 4-to-16 decoder.
- Direct mode: accepts codes through a valid/ready handshake.
- Scan mode: a built-in counter steps through every code with a programmable dwell time.
It drives one-hot select lines (display digits, mux selects, bank enables) and serves as a self-stimulating decoder source for board bring-up.

Parameters:
IN_W, 4, binary code width; output width OUT_W = 2**IN_W (derived localparam, not overridable).
DWELL_W, 8, width of the dwell-time input.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  synchronous, active-high reset.
en  input  1  output enable; 0 blanks output and pauses scan.
mode  input  1  0 = direct, 1 = scan.
in_valid  input  1  code on `in` is valid (direct mode).
in_ready  output  1  block accepts `in` this cycle.
in  input  IN_W  binary code to decode.
dwell  input  DWELL_W  scan mode: cycles per code minus one.
bcode  output  OUT_W  registered one-hot decode.
code  output  IN_W  binary code currently represented by bcode.
out_valid  output  1  bcode holds a valid one-hot value.
wrap  output  1  one-cycle pulse when scan wraps to code 0.

Behaviour:
- Reset (rst=1 at edge): bcode=0, code=0, out_valid=0, wrap=0, dwell counter=0, state=DIRECT. rst has priority over all inputs.
- in_ready is combinational: in_ready = ~rst & ~mode & en. There is no backpressure otherwise.
- States are DIRECT and SCAN; mode is sampled each edge.
  - DIRECT→SCAN when mode=1.
  - SCAN→DIRECT when mode=0.
- DIRECT state:
  - Accept when in_valid & in_ready. Next edge: code=in, bcode=1<<in, out_valid=1. Latency is 1 cycle.
  - Without an accept, bcode, code and out_valid hold.
- DIRECT→SCAN transition edge: code=0, bcode=1 (bit 0), out_valid=en, dwell counter=0.
- SCAN state, en=1:
  - The dwell counter increments each cycle.
  - When counter==dwell: counter clears, code=code+1 modulo 2**IN_W, bcode follows.
  - Each code is therefore held dwell+1 cycles; dwell=0 gives one code per cycle.
  - dwell is sampled continuously. A change mid-dwell applies to the current compare, which must use >=: if counter>=dwell, step immediately.
- Wrap: the step from code 2**IN_W-1 to 0 asserts wrap=1 for exactly the one cycle in which bcode first shows bit 0. wrap is never asserted in DIRECT.
- en=0, either state:
  - Next edge: bcode=0, out_valid=0; code retained.
  - Scan counter and code freeze.
  - Direct accepts are blocked (in_ready=0).
- en 0→1:
  - Next edge: bcode=1<<code, out_valid=1.
  - In SCAN, the dwell counter restarts at 0.
- SCAN→DIRECT: bcode/code/out_valid hold the last scan value until the next accept; wrap=0.
- Simultaneous events:
  - in_valid while mode=1 is ignored.
  - rst together with any input yields reset values.
  - mode toggling every cycle is legal: each SCAN entry restarts at code 0.
- Invariant, checked by assertion: out_valid=1 implies bcode==1<<code. out_valid=0 implies bcode==0.

Test Plan:
- Direct sweep, IN_W=4: after reset, in_valid=1 with in=0..15 on consecutive cycles → bcode=0x0001..0x8000 one cycle later each, code matches, out_valid=1; reset values bcode=0, out_valid=0 confirmed first.
- Scan, IN_W=4, dwell=2: mode=1 → bcode=0x0001 for 3 cycles, then 0x0002, …, 0x8000; after 48 cycles bcode=0x0001 with wrap=1 for exactly 1 cycle; repeat for IN_W=3 (OUT_W=8, wrap every 8*(dwell+1) cycles).
- Enable blanking: scan at code=5, en=0 for 10 cycles → bcode=0, out_valid=0, code stays 5; en=1 → bcode=0x0020 held a full dwell+1 cycles; in direct mode en=0 gives in_ready=0 and in_valid ignored.
- Mode/handshake interaction: mode=1 with in_valid=1, in=9 → in_ready=0, bcode unaffected; mode→0 at code=7 → bcode=0x0080 held, next accept in=2 → 0x0004.
- Mid-operation reset: rst=1 during scan at code=12 with wrap pending → next edge bcode=0, code=0, wrap=0, out_valid=0, state DIRECT, even with mode=1 still high (SCAN re-entered the following edge at code 0).
- dwell=0 and dwell change: dwell=0 → code increments every cycle, wrap every 16 cycles; change dwell 200→1 mid-dwell (counter=50) → step on next edge.
